rd_32b_from_bram: RTL and testbench

Burst reader that fetches a run of 32-bit words from the line-buffer BRAM over the trig/ack request interface and streams them out, masked, on a valid/ready port. It is the read-side counterpart of the BRAM word writer in the connected-domain filter: the filter core uses it to pull stored label/pixel words back for the next pass. Each word is ANDed with a caller-supplied mask before it is presented downstream.

---
 rtl/rd_32b_from_bram.sv | 171 +++++++++++++++++
 tb/tb_rd_32b_from_bram.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_32b_from_bram.sv
// Burst reader: fetches i_rd_len words from BRAM via trig/ack and streams them masked on valid/ready.
// Optional request timeout enabled by defining RD_BRAM_TIMEOUT_EN.
module rd_32b_from_bram #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_trig,
    input  logic [ADDR_W-1:0] i_rd_bram_addr,
    input  logic [LEN_W-1:0]  i_rd_len,
    input  logic [DATA_W-1:0] i_data_mask,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_rd_bram_addr,
    output logic              o_rd_bram_trig,
    input  logic              i_rd_bram_ack,
    input  logic [DATA_W-1:0] i_rd_bram_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              trig_q, trig_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef RD_BRAM_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        mask_d  = mask_q;
        data_d  = data_q;
        trig_d  = trig_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef RD_BRAM_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_trig) begin
                    addr_d = i_rd_bram_addr;
                    rem_d  = i_rd_len;
                    mask_d = i_data_mask;
                    busy_d = 1'b1;
                    if (i_rd_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        trig_d  = 1'b1;
`ifdef RD_BRAM_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                // An ack always wins over an expiring timeout in the same cycle.
                if (i_rd_bram_ack) begin
                    data_d  = i_rd_bram_data & mask_q;
                    valid_d = 1'b1;
                    trig_d  = 1'b0;
                    state_d = S_OUT;
                end
`ifdef RD_BRAM_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    trig_d  = 1'b0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (i_data_ready) begin
                    valid_d = 1'b0;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        trig_d  = 1'b1;
                        state_d = S_REQ;
`ifdef RD_BRAM_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            trig_q  <= trig_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef RD_BRAM_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_rd_bram_addr = addr_q;
    assign o_rd_bram_trig = trig_q;
    assign o_data         = data_q;
    assign o_data_valid   = valid_q;

endmodule

// File: tb/tb_rd_32b_from_bram.sv
// Directed bench for rd_32b_from_bram: BRAM responder, downstream sink, expected-value checks.
// The timeout scenario follows RD_BRAM_TIMEOUT_EN the same way the design does.
module tb_rd_32b_from_bram;

    logic        clk;
    logic        rst;
    logic        i_trig;
    logic [12:0] i_rd_bram_addr;
    logic [7:0]  i_rd_len;
    logic [31:0] i_data_mask;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [12:0] o_rd_bram_addr;
    logic        o_rd_bram_trig;
    logic        i_rd_bram_ack;
    logic [31:0] i_rd_bram_data;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;

    rd_32b_from_bram dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_trig         (i_trig),
        .i_rd_bram_addr (i_rd_bram_addr),
        .i_rd_len       (i_rd_len),
        .i_data_mask    (i_data_mask),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_rd_bram_addr (o_rd_bram_addr),
        .o_rd_bram_trig (o_rd_bram_trig),
        .i_rd_bram_ack  (i_rd_bram_ack),
        .i_rd_bram_data (i_rd_bram_data),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .i_data_ready   (i_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int n_trig_cyc = 0;
    int last_done_cyc = -1;
    int last_hs_cyc = -1;
    int wait_cnt = 0;
    int ack_delay = 0;
    bit ack_en = 1'b1;
    int ready_mode = 0;
    bit use_fixed = 1'b0;
    logic [31:0] fixed_word = 32'h0;
    bit hold_pend = 1'b0;
    logic [31:0] hold_data = 32'h0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [12:0] req_q[$];
    logic [12:0] exp_addr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bram_word(input logic [12:0] a);
        if (use_fixed) return fixed_word;
        return {16'hC0DE, 3'b000, a};
    endfunction

    // One clock: observe outputs at the falling edge, then drive BRAM and sink inputs.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        i_trig = 1'b0;
        if (o_done) begin
            n_done++;
            last_done_cyc = cyc;
        end
        if (o_err) n_err++;
        if (o_rd_bram_trig) n_trig_cyc++;
        if (hold_pend) begin
            check("hold_valid", {31'b0, o_data_valid}, 32'd1);
            check("hold_data", o_data, hold_data);
        end
        if (o_rd_bram_trig && ack_en) begin
            if (wait_cnt == ack_delay) begin
                i_rd_bram_ack  = 1'b1;
                i_rd_bram_data = bram_word(o_rd_bram_addr);
                req_q.push_back(o_rd_bram_addr);
                wait_cnt = 0;
            end else begin
                i_rd_bram_ack  = 1'b0;
                i_rd_bram_data = 32'h5A5A5A5A;
                wait_cnt++;
            end
        end else begin
            i_rd_bram_ack  = 1'b0;
            i_rd_bram_data = 32'hA5A5A5A5;
            wait_cnt = 0;
        end
        if (ready_mode == 1) i_data_ready = ~i_data_ready;
        else i_data_ready = 1'b1;
        if (o_data_valid && i_data_ready) begin
            got_q.push_back(o_data);
            last_hs_cyc = cyc;
        end
        hold_pend = o_data_valid && !i_data_ready;
        hold_data = o_data;
    endtask

    task automatic start(input logic [12:0] a, input logic [7:0] l, input logic [31:0] m);
        got_q.delete();
        exp_q.delete();
        req_q.delete();
        exp_addr_q.delete();
        n_done = 0;
        n_err = 0;
        n_trig_cyc = 0;
        wait_cnt = 0;
        hold_pend = 1'b0;
        @(negedge clk);
        i_trig = 1'b1;
        i_rd_bram_addr = a;
        i_rd_len = l;
        i_data_mask = m;
    endtask

    task automatic wait_done(input int budget);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < budget) begin
            cycle();
            k++;
            if (o_done) seen = 1'b1;
        end
        check("done_reached", {31'b0, seen}, 32'd1);
    endtask

    task automatic compare_streams(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        check({tag, "_reqs"}, req_q.size(), exp_addr_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
        while (req_q.size() > 0 && exp_addr_q.size() > 0)
            check({tag, "_addr"}, {19'b0, req_q.pop_front()}, {19'b0, exp_addr_q.pop_front()});
    endtask

    initial begin
        rst = 1'b1;
        i_trig = 1'b0;
        i_rd_bram_addr = '0;
        i_rd_len = '0;
        i_data_mask = '0;
        i_rd_bram_ack = 1'b0;
        i_rd_bram_data = '0;
        i_data_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_err", {31'b0, o_err}, 32'd0);
        check("rst_trig", {31'b0, o_rd_bram_trig}, 32'd0);
        check("rst_valid", {31'b0, o_data_valid}, 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_addr", {19'b0, o_rd_bram_addr}, 32'd0);
        rst = 1'b0;
        repeat (2) cycle();

        // Single word, 2-cycle ack delay
        use_fixed = 1'b1;
        fixed_word = 32'hDEADBEEF;
        ack_delay = 2;
        ready_mode = 0;
        start(13'h010, 8'd1, 32'h0000FFFF);
        cycle();
        check("t1_busy_n1", {31'b0, o_busy}, 32'd1);
        check("t1_trig_n1", {31'b0, o_rd_bram_trig}, 32'd1);
        check("t1_addr_n1", {19'b0, o_rd_bram_addr}, 32'h010);
        wait_done(50);
        check("t1_err", {31'b0, o_err}, 32'd0);
        check("t1_done_lat", last_done_cyc, last_hs_cyc + 1);
        exp_q.push_back(32'h0000BEEF);
        exp_addr_q.push_back(13'h010);
        compare_streams("t1");
        cycle();
        check("t1_busy_after", {31'b0, o_busy}, 32'd0);
        check("t1_done_pulse", {31'b0, o_done}, 32'd0);
        check("t1_ndone", n_done, 1);

        // Burst of 4 with toggling ready
        use_fixed = 1'b0;
        ack_delay = 0;
        ready_mode = 1;
        start(13'h100, 8'd4, 32'h00FFFFFF);
        wait_done(100);
        repeat (4) cycle();
        exp_q = '{32'h00DE0100, 32'h00DE0101, 32'h00DE0102, 32'h00DE0103};
        exp_addr_q = '{13'h100, 13'h101, 13'h102, 13'h103};
        compare_streams("t2");
        check("t2_ndone", n_done, 1);
        check("t2_nerr", n_err, 0);

        // Address wrap, with an ignored i_trig pulse while busy
        ack_delay = 1;
        ready_mode = 0;
        start(13'd8190, 8'd3, 32'hFFFFFFFF);
        cycle();
        cycle();
        i_trig = 1'b1;
        i_rd_bram_addr = 13'h0AA;
        i_rd_len = 8'd5;
        wait_done(100);
        repeat (4) cycle();
        exp_q = '{32'hC0DE1FFE, 32'hC0DE1FFF, 32'hC0DE0000};
        exp_addr_q = '{13'h1FFE, 13'h1FFF, 13'h0000};
        compare_streams("t3");
        check("t3_ndone", n_done, 1);
        check("t3_idle", {31'b0, o_busy}, 32'd0);

        // Zero length, plus a trig pulse during the done cycle
        start(13'h055, 8'd0, 32'hFFFFFFFF);
        cycle();
        check("t4_done_n1", {31'b0, o_done}, 32'd1);
        check("t4_busy_n1", {31'b0, o_busy}, 32'd1);
        i_trig = 1'b1;
        i_rd_len = 8'd2;
        cycle();
        check("t4_busy_n2", {31'b0, o_busy}, 32'd0);
        check("t4_done_n2", {31'b0, o_done}, 32'd0);
        repeat (4) cycle();
        check("t4_trig_cyc", n_trig_cyc, 0);
        check("t4_ndone", n_done, 1);
        check("t4_busy_end", {31'b0, o_busy}, 32'd0);

        // Reset after 2 of 4 words, then a fresh burst
        ack_delay = 0;
        start(13'h200, 8'd4, 32'hFFFFFFFF);
        begin
            int k;
            k = 0;
            while (got_q.size() < 2 && k < 50) begin
                cycle();
                k++;
            end
        end
        check("t5_two_words", got_q.size(), 2);
        cycle();
        #1;
        rst = 1'b1;
        i_rd_bram_ack = 1'b0;
        hold_pend = 1'b0;
        #1;
        check("t5_rst_busy", {31'b0, o_busy}, 32'd0);
        check("t5_rst_trig", {31'b0, o_rd_bram_trig}, 32'd0);
        check("t5_rst_valid", {31'b0, o_data_valid}, 32'd0);
        check("t5_rst_data", o_data, 32'd0);
        check("t5_rst_addr", {19'b0, o_rd_bram_addr}, 32'd0);
        check("t5_rst_done", {31'b0, o_done}, 32'd0);
        n_done = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();
        check("t5_no_done", n_done, 0);
        start(13'h300, 8'd2, 32'h0000FFFF);
        wait_done(100);
        exp_q = '{32'h00000300, 32'h00000301};
        exp_addr_q = '{13'h300, 13'h301};
        compare_streams("t5");
        cycle();
        check("t5_idle", {31'b0, o_busy}, 32'd0);

        // Unanswered request
        ack_en = 1'b0;
        start(13'h040, 8'd2, 32'hFFFFFFFF);
`ifdef RD_BRAM_TIMEOUT_EN
        wait_done(400);
        check("t6_err", {31'b0, o_err}, 32'd1);
        check("t6_trig_cyc", n_trig_cyc, 255);
        check("t6_trig_low", {31'b0, o_rd_bram_trig}, 32'd0);
        cycle();
        check("t6_idle", {31'b0, o_busy}, 32'd0);
        check("t6_nerr", n_err, 1);
`else
        repeat (1000) cycle();
        check("t6_busy", {31'b0, o_busy}, 32'd1);
        check("t6_trig", {31'b0, o_rd_bram_trig}, 32'd1);
        check("t6_ndone", n_done, 0);
        check("t6_err", {31'b0, o_err}, 32'd0);
`endif
        check("t6_nodata", got_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
